// File: rtl/uart_tx_dev_if.sv
// rtl/uart_tx_dev_if.sv - register bus between the CPU and uart_tx_dev
interface uart_tx_dev_if;
  logic [1:0]  Addr;
  logic        we;
  logic [31:0] data_in;
  logic [31:0] data_out;

  modport master (output Addr, output we, output data_in, input data_out);
  modport slave  (input Addr, input we, input data_in, output data_out);
endinterface

// File: rtl/uart_tx_dev.sv
// rtl/uart_tx_dev.sv - memory-mapped 8N1 UART transmitter with a small TX FIFO
// and a level "transmitter drained" interrupt.
module uart_tx_dev #(
  parameter int unsigned RESET_DIV = 15,
  parameter int unsigned DEPTH     = 4
) (
  input  logic         clk,
  input  logic         reset,
  uart_tx_dev_if.slave bus,
  output logic         IRQ,
  output logic         txd
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_DIV    = 2'd1;
  localparam logic [1:0] A_TXDATA = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [1:0]    ctrl_q;
  logic [15:0]   div_q;
  logic [7:0]    last_q;
  logic          ovf_q;
  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [3:0]    count_q;

  state_t        state_q;
  logic [7:0]    shift_q;
  logic [2:0]    bit_q;
  logic [15:0]   cnt_q;
  logic          txd_q;

  logic          en;
  logic          im;
  logic          empty;
  logic          full;
  logic          busy;
  logic          pop;
  logic          push_req;
  logic          push;
  logic          bit_end;
  logic [15:0]   div_eff;
  logic          unused_data_bits;

  assign en       = ctrl_q[0];
  assign im       = ctrl_q[1];
  assign empty    = (count_q == 4'd0);
  assign full     = (count_q == 4'(DEPTH));
  assign busy     = (state_q != IDLE);
  assign pop      = (state_q == IDLE) && en && !empty;
  assign push_req = bus.we && (bus.Addr == A_TXDATA);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push     = push_req && (!full || pop);
  assign div_eff  = (div_q == 16'd0) ? 16'd1 : div_q;
  assign bit_end  = (cnt_q == 16'd0);

  assign unused_data_bits = ^bus.data_in[31:16];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q   <= '0;
      div_q    <= 16'(RESET_DIV);
      last_q   <= '0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (bus.we) begin
        case (bus.Addr)
          A_CTRL:   ctrl_q <= bus.data_in[1:0];
          A_DIV:    div_q  <= bus.data_in[15:0];
          A_STATUS: if (bus.data_in[7]) ovf_q <= 1'b0;
          default:  ;
        endcase
      end
      if (push_req && !push) begin
        ovf_q <= 1'b1;
      end
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
        last_q   <= bus.data_in[7:0];
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_q + {3'd0, push} - {3'd0, pop};
    end
  end

  // Payload storage is deliberately left out of reset; only pointers/count matter.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.data_in[7:0];
    end
  end

  // cnt_q is reloaded only at bit boundaries, so a DIV write mid-bit waits for the next one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      txd_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            cnt_q   <= div_eff;
            state_q <= START;
            txd_q   <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            cnt_q   <= div_eff;
            bit_q   <= 3'd0;
            state_q <= DATA;
            txd_q   <= shift_q[0];
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_q <= div_eff;
            if (bit_q == 3'd7) begin
              state_q <= STOP;
              txd_q   <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              txd_q   <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            state_q <= IDLE;
            txd_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

  assign IRQ = im & en & empty & ~busy;
  assign txd = txd_q;

  always_comb begin
    bus.data_out = 32'd0;
    case (bus.Addr)
      A_CTRL:   bus.data_out = {30'd0, ctrl_q};
      A_DIV:    bus.data_out = {16'd0, div_q};
      A_TXDATA: bus.data_out = {24'd0, last_q};
      A_STATUS: bus.data_out = {24'd0, ovf_q, count_q[2:0], empty, full, busy, IRQ};
      default:  bus.data_out = 32'd0;
    endcase
  end
endmodule

// File: doc/uart_tx_dev.md
UART_TX_DEV -- requirements
Module: uart_tx_dev

Interface
REQ-001 Parameter RESET_DIV, default 15, SHALL be the reset value of the DIV register; bit period = DIV+1 clk cycles.
REQ-002 Parameter DEPTH, default 4, SHALL be the TX FIFO depth in bytes; legal values are powers of two up to 8.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 Addr  input  2  register select (driven from the bus word address bits [3:2]).
REQ-006 we  input  1  write enable for the selected register, sampled at the rising edge of clk.
REQ-007 data_in  input  32  write data.
REQ-008 data_out  output  32  combinational read data of the selected register.
REQ-009 IRQ  output  1  level interrupt request to the CPU HWInt input.
REQ-010 txd  output  1  serial line, idle high.

Function
REQ-011 Register map SHALL be: 0 CTRL, 1 DIV, 2 TXDATA, 3 STATUS.
REQ-012 CTRL SHALL be {30'b0, IM, EN}; bit0 EN enables transmission, bit1 IM enables IRQ; read returns the stored value.
REQ-013 DIV SHALL be {16'b0, div[15:0]}; writes store data_in[15:0]; values 0 and 1 SHALL be treated as 1 (minimum bit period of 2 cycles).
REQ-014 A write to TXDATA SHALL push data_in[7:0] into the FIFO; a read of TXDATA SHALL return {24'b0, last byte pushed}.
REQ-015 STATUS read SHALL be {24'b0, ovf, count[2:0], empty, full, busy, irq}, with bit0 = IRQ, bit1 = busy, bit2 = full, bit3 = empty, bits[6:4] = count, bit7 = ovf.
REQ-016 A STATUS write with data_in[7]=1 SHALL clear ovf; all other STATUS bits are read-only.
REQ-017 A push while full SHALL be dropped and SHALL set ovf, except when a pop occurs in the same cycle; in that case the push is accepted.
REQ-018 The FSM SHALL have the states IDLE, START, DATA, and STOP.
REQ-019 In IDLE with EN=1 and the FIFO non-empty, the FSM SHALL pop one byte into the shift register on that edge and enter START on the next cycle.
REQ-020 txd SHALL be 0 in START, shift[0] in DATA (LSB first, 8 bits), 1 in STOP, and 1 in IDLE.
REQ-021 Each of START, each DATA bit, and STOP SHALL last exactly DIV+1 cycles, counted by a bit counter reloaded at each bit boundary.
REQ-022 A DIV write during a frame SHALL take effect at the next bit boundary only.
REQ-023 After STOP, the FSM SHALL go to IDLE; back-to-back frames therefore have no extra idle bit, and the pop for the next frame occurs in the IDLE cycle.
REQ-024 Frame length SHALL be 10*(DIV+1) cycles plus 1 IDLE cycle between consecutive frames.
REQ-025 Clearing EN mid-frame SHALL let the current frame complete; no further pops occur while EN=0.
REQ-026 busy SHALL be 1 in any state other than IDLE.
REQ-027 IRQ SHALL equal IM & EN & empty & ~busy (transmitter drained); IRQ is not latched.
REQ-028 count SHALL saturate at DEPTH, with full = (count==DEPTH) and empty = (count==0).
REQ-029 FIFO read/write pointers SHALL wrap modulo DEPTH.

Reset
REQ-030 On reset assertion, the block SHALL asynchronously set CTRL=0, DIV=RESET_DIV, FIFO empty (pointers 0), ovf=0, state=IDLE, txd=1, IRQ=0, and last-pushed byte=0.
REQ-031 A reset mid-frame SHALL abort the frame immediately, with txd high in the same cycle as the reset.
REQ-032 FIFO contents need not be cleared on reset; only pointers and count are reset.

Verification
REQ-033 Reset then STATUS read -> 0x08 (empty); DIV read -> 15; txd=1.
REQ-034 DIV=3, CTRL=1, push 0xA5 -> txd reads 0,1,0,1,0,0,1,0,1,1, each value held 4 cycles; busy high for 40 cycles, then IRQ stays 0 (IM=0).
REQ-035 CTRL=3, DIV=1, push 0x55 then 0x0F -> two frames separated by 1 idle cycle; IRQ rises one cycle after the second stop bit ends.
REQ-036 CTRL=0, push 5 bytes with DEPTH=4 -> STATUS = 0xC4 (ovf=1, count=4, full); write STATUS 0x80 -> ovf cleared.
REQ-037 Mid-DATA assert reset -> txd=1 in the same cycle, STATUS=0x08, and no resumed frame after reset release.
REQ-038 Write DIV=7 during bit 3 of a DIV=3 frame -> bit 3 lasts 4 cycles and bit 4 onward last 8 cycles.
